// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: register-address width, the hazard tracker
// entry format and a helper that tests one entry against a source register.
package cpu_pkg;

    localparam int unsigned RF_AW = 5;
    localparam logic [RF_AW-1:0] ZERO_REG = '0;

    // One in-flight instruction as seen by the hazard tracker
    typedef struct packed {
        logic [RF_AW-1:0] dst;
        logic             we;
        logic             ld;
        logic             ext;
    } track_ent_t;

    localparam track_ent_t ENT_NOP = '0;

    // True when the entry will write the register being read
    function automatic logic ent_hit(input track_ent_t e, input logic [RF_AW-1:0] src);
        return e.we && (e.dst == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the ID stage/pipeline control and hazard_ctrl.
//   master: ID-stage decode info and dm_wait out, bypass/stall controls in
//   slave : the hazard controller (the inverse)
interface hazard_ctrl_if #(
    parameter int unsigned AW = cpu_pkg::RF_AW
);
    logic          vld_ID;
    logic [AW-1:0] src0_addr_ID;
    logic [AW-1:0] src1_addr_ID;
    logic          re0_ID;
    logic          re1_ID;
    logic [AW-1:0] dst_addr_ID;
    logic          we_ID;
    logic          ld_ID;
    logic          ext_ID;
    logic          dm_wait;

    logic          byp0_EX;
    logic          byp1_EX;
    logic          byp0_ext_EX;
    logic          byp1_ext_EX;
    logic          byp0_DM;
    logic          byp1_DM;
    logic          stall_IF_ID;
    logic          stall_ID_EX;
    logic          stall_EX_DM;
    logic          bubble_ID_EX;

    modport master (
        output vld_ID, src0_addr_ID, src1_addr_ID, re0_ID, re1_ID,
               dst_addr_ID, we_ID, ld_ID, ext_ID, dm_wait,
        input  byp0_EX, byp1_EX, byp0_ext_EX, byp1_ext_EX, byp0_DM, byp1_DM,
               stall_IF_ID, stall_ID_EX, stall_EX_DM, bubble_ID_EX
    );

    modport slave (
        input  vld_ID, src0_addr_ID, src1_addr_ID, re0_ID, re1_ID,
               dst_addr_ID, we_ID, ld_ID, ext_ID, dm_wait,
        output byp0_EX, byp1_EX, byp0_ext_EX, byp1_ext_EX, byp0_DM, byp1_DM,
               stall_IF_ID, stall_ID_EX, stall_EX_DM, bubble_ID_EX
    );

endinterface

// File: rtl/ext_busy_cnt.sv
// Down-counter tracking how many more cycles an ext op occupies EX.
//   clk, rst_n : clock, async active-low reset
//   load       : ext op enters ID_EX; counter loads EXT_LAT-1
//   hold       : freeze (data-memory wait)
//   busy       : counter nonzero
module ext_busy_cnt #(
    parameter int unsigned EXT_LAT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic hold,
    output logic busy
);

    localparam int unsigned CW = (EXT_LAT > 1) ? $clog2(EXT_LAT) : 1;

    logic [CW-1:0] cnt;

    assign busy = (cnt != '0);

    // Load on ext entry, otherwise count down to zero unless frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!hold) begin
            if (load) begin
                cnt <= CW'(EXT_LAT - 1);
            end else if (busy) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard and forwarding controller for the 5-stage pipeline.
// Tracks in-flight destinations (ID_EX, EX_DM, DM_WB), drives registered
// EX-stage bypass selects and combinational stall/bubble controls.
//   clk, rst_n : clock, async active-low reset
//   hz (slave) : ID decode info, dm_wait, bypass selects, stalls, bubble
// Build option: HAZARD_FWD_DM_EN enables forwarding from DM_WB; without it an
// EX_DM match costs a one-cycle bubble instead.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned EXT_LAT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);

    track_ent_t       ent_id_ex, ent_ex_dm, ent_dm_wb, ent_new;
    logic [RF_AW-1:0] src [2];
    logic [1:0]       re, req, hit_a, hit_b;
    logic [1:0]       byp_ex_d, byp_ext_d, byp_dm_d, lu;
    logic [1:0]       byp_ex_q, byp_ext_q, byp_dm_q;
    logic             busy, bubble, stall_id_ex, ext_load;
    logic             unused;

    // DM_WB is covered by register-file write-through; kept for occupancy only
    assign unused = ^{ent_dm_wb, ent_ex_dm.ld, ent_ex_dm.ext};

    // Per-port hazard detection; ID_EX (youngest) takes priority over EX_DM
    always_comb begin
        src[0]    = hz.src0_addr_ID;
        src[1]    = hz.src1_addr_ID;
        re        = {hz.re1_ID, hz.re0_ID};
        req       = '0;
        hit_a     = '0;
        hit_b     = '0;
        byp_ex_d  = '0;
        byp_ext_d = '0;
        byp_dm_d  = '0;
        lu        = '0;
        for (int n = 0; n < 2; n++) begin
            req[n]       = re[n] & hz.vld_ID & (src[n] != ZERO_REG);
            hit_a[n]     = req[n] & ent_hit(ent_id_ex, src[n]);
            hit_b[n]     = req[n] & ent_hit(ent_ex_dm, src[n]);
            byp_ex_d[n]  = hit_a[n] & ~ent_id_ex.ext & ~ent_id_ex.ld;
            byp_ext_d[n] = hit_a[n] & ent_id_ex.ext;
`ifdef HAZARD_FWD_DM_EN
            byp_dm_d[n]  = ~hit_a[n] & hit_b[n];
            lu[n]        = hit_a[n] & ent_id_ex.ld & ~ent_id_ex.ext;
`else
            lu[n]        = (hit_a[n] & ent_id_ex.ld & ~ent_id_ex.ext) | (~hit_a[n] & hit_b[n]);
`endif
        end
    end

    // dm_wait beats the ext stall, which beats a load-use bubble
    assign stall_id_ex     = hz.dm_wait | busy;
    assign bubble          = ~stall_id_ex & (|lu);
    assign hz.stall_IF_ID  = stall_id_ex | bubble;
    assign hz.stall_ID_EX  = stall_id_ex;
    assign hz.stall_EX_DM  = hz.dm_wait;
    assign hz.bubble_ID_EX = bubble;

    // Entry for the instruction leaving ID; r0 and squashed slots never write
    always_comb begin
        ent_new     = ENT_NOP;
        ent_new.dst = hz.dst_addr_ID;
        ent_new.we  = hz.we_ID & hz.vld_ID & (hz.dst_addr_ID != ZERO_REG);
        ent_new.ld  = hz.ld_ID;
        ent_new.ext = hz.ext_ID;
    end

    assign ext_load = hz.vld_ID & hz.ext_ID & ~stall_id_ex & ~bubble;

    ext_busy_cnt #(
        .EXT_LAT (EXT_LAT)
    ) u_ext_busy_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ext_load),
        .hold  (hz.dm_wait),
        .busy  (busy)
    );

    // Tracker: freeze on dm_wait, hold ID_EX during ext stall, else shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_id_ex <= ENT_NOP;
            ent_ex_dm <= ENT_NOP;
            ent_dm_wb <= ENT_NOP;
        end else if (!hz.dm_wait) begin
            if (busy) begin
                ent_ex_dm <= ENT_NOP;
            end else begin
                ent_id_ex <= bubble ? ENT_NOP : ent_new;
                ent_ex_dm <= ent_id_ex;
            end
            ent_dm_wb <= ent_ex_dm;
        end
    end

    // Bypass selects follow the consumer into EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_ex_q  <= '0;
            byp_ext_q <= '0;
            byp_dm_q  <= '0;
        end else if (bubble) begin
            byp_ex_q  <= '0;
            byp_ext_q <= '0;
            byp_dm_q  <= '0;
        end else if (!stall_id_ex) begin
            byp_ex_q  <= byp_ex_d;
            byp_ext_q <= byp_ext_d;
            byp_dm_q  <= byp_dm_d;
        end
    end

    assign hz.byp0_EX     = byp_ex_q[0];
    assign hz.byp1_EX     = byp_ex_q[1];
    assign hz.byp0_ext_EX = byp_ext_q[0];
    assign hz.byp1_ext_EX = byp_ext_q[1];
    assign hz.byp0_DM     = byp_dm_q[0];
    assign hz.byp1_DM     = byp_dm_q[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (EXT_LAT=3). Expected output vectors are
// queued as each step is driven and popped when the outputs are sampled.
// Honours HAZARD_FWD_DM_EN for the DM-forwarding expectations.
module tb_hazard_ctrl;

    // Output vector bit positions
    localparam logic [9:0] E0 = 10'b10_0000_0000;  // byp0_EX
    localparam logic [9:0] E1 = 10'b01_0000_0000;  // byp1_EX
    localparam logic [9:0] X0 = 10'b00_1000_0000;  // byp0_ext_EX
    localparam logic [9:0] D0 = 10'b00_0010_0000;  // byp0_DM
    localparam logic [9:0] D1 = 10'b00_0001_0000;  // byp1_DM
    localparam logic [9:0] SI = 10'b00_0000_1000;  // stall_IF_ID
    localparam logic [9:0] SD = 10'b00_0000_0100;  // stall_ID_EX
    localparam logic [9:0] SE = 10'b00_0000_0010;  // stall_EX_DM
    localparam logic [9:0] BB = 10'b00_0000_0001;  // bubble_ID_EX
    localparam logic [9:0] NO = 10'b00_0000_0000;

    typedef struct {
        string      tag;
        logic [9:0] v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] obs;
    exp_t       sb [$];
    int         n_chk = 0;
    int         n_fail = 0;

    hazard_ctrl_if bus ();

    hazard_ctrl #(
        .EXT_LAT (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus)
    );

    always #5 clk = ~clk;

    assign obs = {bus.byp0_EX, bus.byp1_EX, bus.byp0_ext_EX, bus.byp1_ext_EX,
                  bus.byp0_DM, bus.byp1_DM, bus.stall_IF_ID, bus.stall_ID_EX,
                  bus.stall_EX_DM, bus.bubble_ID_EX};

    task automatic id(input logic v, input logic [4:0] s0, input logic r0,
                      input logic [4:0] s1, input logic r1, input logic [4:0] d,
                      input logic w, input logic l, input logic x);
        bus.vld_ID       = v;
        bus.src0_addr_ID = s0;
        bus.re0_ID       = r0;
        bus.src1_addr_ID = s1;
        bus.re1_ID       = r1;
        bus.dst_addr_ID  = d;
        bus.we_ID        = w;
        bus.ld_ID        = l;
        bus.ext_ID       = x;
    endtask

    task automatic nop();
        id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Queue expectation for this cycle, sample mid-cycle, advance to next negedge
    task automatic cyc(input string tag, input logic [9:0] exp);
        exp_t e;
        sb.push_back('{tag, exp});
        #2;
        e = sb.pop_front();
        n_chk++;
        assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
        end
        @(negedge clk);
    endtask

    task automatic flush();
        nop(); cyc("flush_a", NO);
        nop(); cyc("flush_b", NO);
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.dm_wait = 1'b0;
        nop();
        @(negedge clk);
        cyc("reset", NO);
        rst_n = 1'b1;

        // ADD r3 ; ADD r4,r3,r3
        id(1, 0, 0, 0, 0, 3, 1, 0, 0);   cyc("add_w", NO);
        id(1, 3, 1, 3, 1, 4, 1, 0, 0);   cyc("add_r_id", NO);
        nop();                           cyc("add_r_ex", E0 | E1);
        flush();

        // LW r5 ; SUB r6,r5,r1
        id(1, 0, 0, 0, 0, 5, 1, 1, 0);   cyc("lw", NO);
        id(1, 5, 1, 1, 1, 6, 1, 0, 0);   cyc("lu_1", SI | BB);
`ifdef HAZARD_FWD_DM_EN
        cyc("lu_go", NO);
        nop();                           cyc("lu_byp", D0);
`else
        cyc("lu_2", SI | BB);
        cyc("lu_go", NO);
        nop();                           cyc("lu_byp", NO);
`endif
        flush();

        // ext r7 ; reader of r7
        id(1, 0, 0, 0, 0, 7, 1, 0, 1);   cyc("ext", NO);
        id(1, 7, 1, 0, 0, 8, 1, 0, 0);   cyc("ext_s1", SI | SD);
        cyc("ext_s2", SI | SD);
        cyc("ext_go", NO);
        nop();                           cyc("ext_byp", X0);
        flush();

        // r0 writer/reader, also as a load
        id(1, 0, 0, 0, 0, 0, 1, 0, 0);   cyc("r0_w", NO);
        id(1, 0, 1, 0, 1, 0, 1, 1, 0);   cyc("r0_rw_ld", NO);
        id(1, 0, 1, 0, 1, 9, 1, 0, 0);   cyc("r0_r_after_ld", NO);
        nop();                           cyc("r0_ex", NO);
        flush();

        // re gating: only port 1 reads r9
        id(1, 0, 0, 0, 0, 9, 1, 0, 0);   cyc("re_w", NO);
        id(1, 9, 0, 9, 1, 2, 1, 0, 0);   cyc("re_r", NO);
        nop();                           cyc("re_ex", E1);
        flush();

        // invalid reader sees nothing
        id(1, 0, 0, 0, 0, 15, 1, 0, 0);  cyc("vld_w", NO);
        id(0, 15, 1, 15, 1, 2, 1, 0, 0); cyc("vld_r", NO);
        nop();                           cyc("vld_ex", NO);
        flush();

        // youngest match wins: two writers of r12
        id(1, 0, 0, 0, 0, 12, 1, 0, 0);  cyc("yng_w1", NO);
        id(1, 0, 0, 0, 0, 12, 1, 0, 0);  cyc("yng_w2", NO);
        id(1, 12, 1, 0, 0, 2, 1, 0, 0);  cyc("yng_r", NO);
        nop();                           cyc("yng_ex", E0);
        flush();

        // EX_DM match of a non-load
        id(1, 0, 0, 0, 0, 13, 1, 0, 0);  cyc("exdm_w", NO);
        nop();                           cyc("exdm_gap", NO);
        id(1, 13, 1, 0, 0, 2, 1, 0, 0);
`ifdef HAZARD_FWD_DM_EN
        cyc("exdm_r", NO);
        nop();                           cyc("exdm_ex", D0);
`else
        cyc("exdm_r", SI | BB);
        cyc("exdm_go", NO);
        nop();                           cyc("exdm_ex", NO);
`endif
        flush();

        // dm_wait during a load-use stall on port 1
        id(1, 0, 0, 0, 0, 10, 1, 1, 0);  cyc("dmw_lw", NO);
        id(1, 0, 0, 10, 1, 11, 1, 0, 0);
        bus.dm_wait = 1'b1;
        cyc("dmw_1", SI | SD | SE);
        cyc("dmw_2", SI | SD | SE);
        cyc("dmw_3", SI | SD | SE);
        bus.dm_wait = 1'b0;
        cyc("dmw_lu", SI | BB);
`ifdef HAZARD_FWD_DM_EN
        cyc("dmw_go", NO);
        nop();                           cyc("dmw_byp", D1);
`else
        cyc("dmw_lu2", SI | BB);
        cyc("dmw_go", NO);
        nop();                           cyc("dmw_byp", NO);
`endif
        flush();

        // async reset during an ext stall
        id(1, 0, 0, 0, 0, 14, 1, 0, 1);  cyc("rst_ext", NO);
        id(1, 14, 1, 0, 0, 2, 1, 0, 0);  cyc("rst_pre", SI | SD);
        rst_n = 1'b0;
        cyc("rst_async", NO);
        rst_n = 1'b1;
        cyc("rst_after", NO);
        nop();                           cyc("rst_idle", NO);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

ID-stage hazard and forwarding controller for the 5-stage CPU pipeline. It tracks the destination register of every in-flight instruction and drives the bypass selects consumed by the EX-stage source mux: `byp0/1_EX`, `byp0/1_ext_EX` and `byp0/1_DM`. It also generates the pipeline stall and bubble controls for load-use hazards, multicycle extended-unit (ext) ops and data-memory wait states.

## Interface
Parameters:
- `RF_AW`, 5: register-address width. Register 0 is hardwired zero.
- `EXT_LAT`, 3: number of cycles an ext op occupies EX (≥1).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `vld_ID`  in  1  the ID instruction is valid (0 means squashed or bubble).
- `src0_addr_ID`, `src1_addr_ID`  in  RF_AW  source register addresses.
- `re0_ID`, `re1_ID`  in  1  the corresponding source is actually read.
- `dst_addr_ID`  in  RF_AW  destination register address.
- `we_ID`  in  1  the instruction writes the register file.
- `ld_ID`  in  1  the instruction is a load (LW).
- `ext_ID`  in  1  the instruction is an ext-unit op.
- `dm_wait`  in  1  data memory not ready; freezes the whole pipeline.
- `byp0_EX`, `byp1_EX`  out  1  forward from `dst_EX_DM`.
- `byp0_ext_EX`, `byp1_ext_EX`  out  1  forward from `dst_ext_EX_DM`.
- `byp0_DM`, `byp1_DM`  out  1  forward from `dst_DM_WB`.
- `stall_IF_ID`, `stall_ID_EX`, `stall_EX_DM`  out  1  hold the respective pipeline registers.
- `bubble_ID_EX`  out  1  load a NOP into ID_EX this cycle.

## Operation
- Tracker: three entries (ID_EX, EX_DM, DM_WB). Each entry holds `{dst, we, ld, ext}`, and `we` is forced to 0 when `dst==0` or `!vld`.
- Tracker advance, normal case: entries shift one stage per cycle.
- Tracker advance on `bubble_ID_EX`: ID_EX receives `we=0`.
- Tracker advance during an ext stall: ID_EX holds and EX_DM receives `we=0`.
- Tracker advance on `dm_wait`: all entries hold.
- Hazard test for port n: `re_n && vld_ID && src_n != 0` matched against each entry with `we=1`. The youngest matching entry wins.
- Match in ID_EX, non-load, non-ext: next `bypn_EX=1`.
- Match in ID_EX, ext op: next `bypn_ext_EX=1`.
- Match in ID_EX, load: load-use hazard. Assert `stall_IF_ID=1` and `bubble_ID_EX=1` for 1 cycle. The consumer then sees the load in EX_DM.
- Match in EX_DM, any kind including a load: next `bypn_DM=1`.
- Match in DM_WB only: no bypass; the register file write-through covers it.
- Bypass outputs are registered. They load whenever `!stall_ID_EX`, are cleared when `bubble_ID_EX` is asserted, and are one-hot per port.
- Ext busy counter:
  - Loads `EXT_LAT-1` when an ext op with `vld` enters ID_EX.
  - While the counter is nonzero: `stall_IF_ID=1`, `stall_ID_EX=1`, and the counter decrements each cycle without `dm_wait`.
  - `EXT_LAT=1` never stalls.
- `dm_wait=1`: all three stalls are 1, `bubble_ID_EX=0`, and the counter and tracker freeze.
- Simultaneous events:
  - `dm_wait` overrides everything.
  - An ext stall overrides a load-use hazard; the load-use check is re-evaluated after the ext stall ends.

## Timing
- Reset: all outputs are 0, tracker `we` bits are 0 and the counter is 0.
- Reset mid-operation discards every pending stall and bypass immediately (asynchronous).
- The stall and bubble outputs are combinational from the ID inputs and registered state, within the same cycle.
- Bypass selects are valid in the cycle the consumer occupies EX, one clock after the hazard is detected in ID.
- Load-use penalty: 1 cycle with `FWD_DM_EN`, 2 cycles without.
- Ext penalty: `EXT_LAT-1` cycles.

## Configuration
- `HAZARD_FWD_DM_EN` defined: DM_WB forwarding is enabled as described above.
- `HAZARD_FWD_DM_EN` undefined:
  - `byp0_DM` and `byp1_DM` are tied to 0.
  - A match in EX_DM stalls 1 cycle (`stall_IF_ID` plus `bubble_ID_EX`).
  - A load match in ID_EX stalls 2 cycles in total.

## Structure
- Shared package `cpu_pkg`: `RF_AW`, the `track_ent_t` struct `{dst, we, ld, ext}` and the zero-register constant.
- Sub-module `ext_busy_cnt`:
  - Ports: `clk`, `rst_n`, `load`, `hold`, `busy`.
  - It is a down-counter of width `$clog2(EXT_LAT)`.

## Test plan
- ADD r3 then ADD r4,r3,r3 back-to-back -> `byp0_EX=1` and `byp1_EX=1` in the consumer's EX cycle, no stall.
- LW r5 then SUB r6,r5,r1 -> 1 cycle with `stall_IF_ID=1` and `bubble_ID_EX=1`, then `byp0_DM=1`. Without the macro: 2 stall cycles and `byp0_DM=0`.
- Ext op writing r7 with `EXT_LAT=3`, followed by a reader of r7 -> 2 cycles of `stall_ID_EX=1`, then `byp0_ext_EX=1`.
- Writer and reader targeting r0 -> no bypass and no stall.
- `dm_wait=1` for 3 cycles during a load-use stall -> all stalls high, tracker frozen, correct bypass after release.
- `rst_n` pulsed low during an ext stall -> all outputs 0 asynchronously and the counter reads 0 after release.
